// File: rtl/input_cond_pkg.sv
// Shared constants for the board input conditioner: mode FSM encoding,
// default timing values and button/switch bit positions.
package input_cond_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ESCRIBE   = 3'd1,
    ST_CRONO     = 3'd2,
    ST_RESET     = 3'd3,
    ST_CR_ACTIVO = 3'd4
  } mode_state_t;

  localparam int DEF_DEB_CYCLES    = 1_000_000;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 20_000_000;
  localparam int DEF_CNT_W         = 26;

  localparam int NUM_BTN = 4;
  localparam int NUM_SW  = 4;

  // Opposing buttons sit on adjacent even/odd positions.
  localparam int BTN_ARRIBA    = 0;
  localparam int BTN_ABAJO     = 1;
  localparam int BTN_IZQUIERDA = 2;
  localparam int BTN_DERECHA   = 3;

  localparam int SW_ESCRIBE   = 0;
  localparam int SW_CRONO     = 1;
  localparam int SW_RESET     = 2;
  localparam int SW_CR_ACTIVO = 3;

  function automatic int opposite_btn(input int idx);
    return idx ^ 1;
  endfunction

  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Board-side signal bundle: raw buttons/switches in, edit pulses and mode levels out.
interface input_conditioner_if;
  logic btn_arriba, btn_abajo, btn_izquierda, btn_derecha;
  logic sw_escribe, sw_crono, sw_reset, sw_cr_activo;
  logic push_arriba, push_abajo, push_izquierda, push_derecha;
  logic escribe1, crono1, reset1, cr_activo1;
  logic sw_conflict;

  modport master (
    output btn_arriba, btn_abajo, btn_izquierda, btn_derecha,
    output sw_escribe, sw_crono, sw_reset, sw_cr_activo,
    input  push_arriba, push_abajo, push_izquierda, push_derecha,
    input  escribe1, crono1, reset1, cr_activo1, sw_conflict
  );

  modport slave (
    input  btn_arriba, btn_abajo, btn_izquierda, btn_derecha,
    input  sw_escribe, sw_crono, sw_reset, sw_cr_activo,
    output push_arriba, push_abajo, push_izquierda, push_derecha,
    output escribe1, crono1, reset1, cr_activo1, sw_conflict
  );
endinterface

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stability counter; the output level only
// follows the synced input after DEB_CYCLES consecutive differing samples.
module debounce_filter
  import input_cond_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // synchronise, then count how long the synced value has disagreed with the level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= {CNT_W{1'b0}};
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_level) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (r_cnt == DEB_LIM) begin
        r_level <= r_sync[1];
        r_cnt   <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw board buttons into edit pulses with hold-to-repeat and raw
// switches into an exclusive, registered mode selection.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input logic            clk,
  input logic            reset,
  input_conditioner_if.slave io
);

  localparam int NUM_IN = NUM_BTN + NUM_SW;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_IN-1:0]  w_raw;
  logic [NUM_IN-1:0]  w_deb;
  logic [NUM_BTN-1:0] w_btn_deb;
  logic [NUM_SW-1:0]  w_sw_deb;
  logic [NUM_BTN-1:0] w_act;
  logic [NUM_BTN-1:0] w_fire;

  logic [NUM_BTN-1:0] r_push;
  logic [NUM_BTN-1:0] r_act_prev;
  logic [NUM_BTN-1:0] r_phase;
  logic [CNT_W-1:0]   r_rep_cnt [NUM_BTN];
  mode_state_t        r_state;
  logic [NUM_SW-1:0]  r_mode;
  logic               r_conflict;

  assign w_raw[BTN_ARRIBA]           = io.btn_arriba;
  assign w_raw[BTN_ABAJO]            = io.btn_abajo;
  assign w_raw[BTN_IZQUIERDA]        = io.btn_izquierda;
  assign w_raw[BTN_DERECHA]          = io.btn_derecha;
  assign w_raw[NUM_BTN+SW_ESCRIBE]   = io.sw_escribe;
  assign w_raw[NUM_BTN+SW_CRONO]     = io.sw_crono;
  assign w_raw[NUM_BTN+SW_RESET]     = io.sw_reset;
  assign w_raw[NUM_BTN+SW_CR_ACTIVO] = io.sw_cr_activo;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_deb
    debounce_filter #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .i_clk  (clk),
      .i_rst_n(reset),
      .i_raw  (w_raw[g]),
      .o_level(w_deb[g])
    );
  end

  assign w_btn_deb = w_deb[NUM_BTN-1:0];
  assign w_sw_deb  = w_deb[NUM_IN-1:NUM_BTN];

  // A button is live only while its opposite is released; its first live cycle
  // fires immediately, later fires come from the hold/repeat counter.
  always_comb begin
    w_act  = 4'b0000;
    w_fire = 4'b0000;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_act[i]  = w_btn_deb[i] & ~w_btn_deb[opposite_btn(i)];
      w_fire[i] = w_act[i] & (~r_act_prev[i] |
                  (r_rep_cnt[i] == (r_phase[i] ? REP_LIM : HOLD_LIM)));
    end
  end

  // pulse registers and per-button repeat counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_push     <= 4'b0000;
      r_act_prev <= 4'b0000;
      r_phase    <= 4'b0000;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_rep_cnt[i] <= {CNT_W{1'b0}};
      end
    end else begin
      r_push     <= w_fire;
      r_act_prev <= w_act;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!w_act[i]) begin
          r_rep_cnt[i] <= {CNT_W{1'b0}};
          r_phase[i]   <= 1'b0;
        end else if (w_fire[i]) begin
          r_rep_cnt[i] <= {CNT_W{1'b0}};
          r_phase[i]   <= r_act_prev[i];
        end else if (r_rep_cnt[i] != CNT_MAX) begin
          r_rep_cnt[i] <= r_rep_cnt[i] + CNT_ONE;
        end else begin
          r_rep_cnt[i] <= r_rep_cnt[i];
        end
      end
    end
  end

  // mode FSM; outputs are registered decodes of the current state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_mode     <= 4'b0000;
      r_conflict <= 1'b0;
    end else begin
      r_mode[SW_ESCRIBE]   <= (r_state == ST_ESCRIBE);
      r_mode[SW_CRONO]     <= (r_state == ST_CRONO);
      r_mode[SW_RESET]     <= (r_state == ST_RESET);
      r_mode[SW_CR_ACTIVO] <= (r_state == ST_CR_ACTIVO);
      r_conflict           <= (r_state == ST_IDLE) && multi_hot(w_sw_deb);
      case (r_state)
        ST_IDLE: begin
          case (w_sw_deb)
            4'b0001: r_state <= ST_ESCRIBE;
            4'b0010: r_state <= ST_CRONO;
            4'b0100: r_state <= ST_RESET;
            4'b1000: r_state <= ST_CR_ACTIVO;
            default: r_state <= ST_IDLE;
          endcase
        end
        ST_ESCRIBE:   r_state <= w_sw_deb[SW_ESCRIBE]   ? ST_ESCRIBE   : ST_IDLE;
        ST_CRONO:     r_state <= w_sw_deb[SW_CRONO]     ? ST_CRONO     : ST_IDLE;
        ST_RESET:     r_state <= w_sw_deb[SW_RESET]     ? ST_RESET     : ST_IDLE;
        ST_CR_ACTIVO: r_state <= w_sw_deb[SW_CR_ACTIVO] ? ST_CR_ACTIVO : ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

  assign io.push_arriba    = r_push[BTN_ARRIBA];
  assign io.push_abajo     = r_push[BTN_ABAJO];
  assign io.push_izquierda = r_push[BTN_IZQUIERDA];
  assign io.push_derecha   = r_push[BTN_DERECHA];
  assign io.escribe1       = r_mode[SW_ESCRIBE];
  assign io.crono1         = r_mode[SW_CRONO];
  assign io.reset1         = r_mode[SW_RESET];
  assign io.cr_activo1     = r_mode[SW_CR_ACTIVO];
  assign io.sw_conflict    = r_conflict;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench: every cycle is compared against a window/run-length
// reference model of the conditioner, plus directed checks on key scenarios.
module tb_input_conditioner;

  localparam int DEB    = 4;
  localparam int HOLD   = 20;
  localparam int REP    = 8;
  localparam int MAXC   = 4000;
  localparam int IDLE_M = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] sw  = 4'b0000;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  always #5 clk = ~clk;

  assign bus.btn_arriba    = btn[0];
  assign bus.btn_abajo     = btn[1];
  assign bus.btn_izquierda = btn[2];
  assign bus.btn_derecha   = btn[3];
  assign bus.sw_escribe    = sw[0];
  assign bus.sw_crono      = sw[1];
  assign bus.sw_reset      = sw[2];
  assign bus.sw_cr_activo  = sw[3];

  logic [3:0] push_o, mode_o;
  logic       conflict_o;
  assign push_o     = {bus.push_derecha, bus.push_izquierda, bus.push_abajo, bus.push_arriba};
  assign mode_o     = {bus.cr_activo1, bus.reset1, bus.crono1, bus.escribe1};
  assign conflict_o = bus.sw_conflict;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model history, indexed by cycle number
  logic [7:0] raw_h [MAXC];
  logic [7:0] deb_h [MAXC];
  logic [3:0] act_h [MAXC];
  int         st_h  [MAXC];

  int n_checks = 0;
  int n_errors = 0;
  int t_mark = 0;
  int pcnt [4];
  int pfirst [4];
  int rep_q [$];
  int lat;
  int exp_ofs [6] = '{7, 27, 35, 43, 51, 59};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic raw_at(input int k, input int i);
    if (k < 0) return 1'b0;
    return raw_h[k][i];
  endfunction

  // pulse at n if the button has been live continuously since cycle a and
  // n-1-a is 0, HOLD, or HOLD plus a whole number of REPEAT periods
  function automatic logic pulse_due(input int b, input int n);
    int a, d;
    if (n < 1) return 1'b0;
    if (!act_h[n-1][b]) return 1'b0;
    a = n - 1;
    while (a > 0 && act_h[a-1][b]) a--;
    d = n - 1 - a;
    return (d == 0) || (d == HOLD) || (d > HOLD && ((d - HOLD) % REP) == 0);
  endfunction

  task automatic check_cycle();
    int n, ps, ns;
    logic [7:0] d;
    logic [3:0] a, ep, em, swp;
    logic ec, same;
    n  = cyc;
    ep = 4'b0000;
    em = 4'b0000;
    ec = 1'b0;
    d  = 8'h00;
    a  = 4'b0000;
    if (!reset) begin
      deb_h[n] = 8'h00;
      act_h[n] = 4'b0000;
      st_h[n]  = IDLE_M;
    end else begin
      for (int i = 0; i < 8; i++) begin
        same = 1'b1;
        for (int k = n - DEB - 2; k <= n - 3; k++)
          if (raw_at(k, i) != raw_at(n - 3, i)) same = 1'b0;
        d[i] = same ? raw_at(n - 3, i) : deb_h[n-1][i];
      end
      deb_h[n] = d;
      for (int b = 0; b < 4; b++) a[b] = d[b] & ~d[b^1];
      act_h[n] = a;
      for (int b = 0; b < 4; b++) ep[b] = pulse_due(b, n);
      ps  = st_h[n-1];
      swp = deb_h[n-1][7:4];
      ns  = ps;
      if (ps == IDLE_M) begin
        if ($countones(swp) == 1)
          for (int s = 0; s < 4; s++) if (swp[s]) ns = s;
      end else if (!swp[ps]) begin
        ns = IDLE_M;
      end
      st_h[n] = ns;
      if (ps != IDLE_M) em[ps] = 1'b1;
      ec = (ps == IDLE_M) && ($countones(swp) > 1);
    end
    chk("push", {28'd0, push_o}, {28'd0, ep});
    chk("mode", {28'd0, mode_o}, {28'd0, em});
    chk("conflict", {31'd0, conflict_o}, {31'd0, ec});
  endtask

  task automatic run(input int k);
    for (int j = 0; j < k; j++) begin
      if (cyc >= MAXC - 1) begin
        $display("FAIL budget: cycle %0d reached limit %0d", cyc, MAXC);
        $fatal(1, "cycle budget exceeded");
      end
      raw_h[cyc] = reset ? {sw, btn} : 8'h00;
      @(negedge clk);
      check_cycle();
      for (int b = 0; b < 4; b++) begin
        if (push_o[b]) begin
          if (pcnt[b] == 0) pfirst[b] = cyc - t_mark;
          pcnt[b]++;
          if (b == 3) rep_q.push_back(cyc - t_mark);
        end
      end
    end
  endtask

  task automatic clear_log();
    for (int b = 0; b < 4; b++) begin
      pcnt[b]   = 0;
      pfirst[b] = -1;
    end
    rep_q.delete();
  endtask

  task automatic wait_mode(input int idx, input int limit, output int l);
    l = -1;
    for (int k = 1; k <= limit; k++) begin
      run(1);
      if (mode_o[idx]) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      raw_h[k] = 8'h00;
      deb_h[k] = 8'h00;
      act_h[k] = 4'b0000;
      st_h[k]  = IDLE_M;
    end
    clear_log();
    run(3);
    #1 reset = 1'b1;
    run(4);

    // clean press
    clear_log(); btn[0] = 1'b1; t_mark = cyc; run(10); btn[0] = 1'b0; run(15);
    chk("press_cnt", pcnt[0], 1);
    chk("press_lat", pfirst[0], 7);

    // bounce shorter than the debounce window
    clear_log();
    for (int i = 0; i < 10; i++) begin btn[1] = ~btn[1]; run(2); end
    btn[1] = 1'b0; run(15);
    chk("bounce_cnt", pcnt[1], 0);

    // auto-repeat
    clear_log(); btn[3] = 1'b1; t_mark = cyc; run(60); btn[3] = 1'b0; run(20);
    chk("rep_cnt", rep_q.size(), 6);
    for (int i = 0; i < 6 && i < rep_q.size(); i++) chk("rep_ofs", rep_q[i], exp_ofs[i]);

    // opposing pair
    clear_log(); btn[2] = 1'b1; btn[3] = 1'b1; run(30);
    chk("opp_both", pcnt[2] + pcnt[3], 0);
    btn[3] = 1'b0; t_mark = cyc; run(15);
    chk("opp_izq_cnt", pcnt[2], 1);
    chk("opp_izq_lat", pfirst[2], 7);
    chk("opp_der_cnt", pcnt[3], 0);
    btn[2] = 1'b0; run(15);

    // mode exclusivity
    sw = 4'b0001; wait_mode(0, 20, lat);
    chk("esc_lat", lat, 8);
    sw = 4'b0011; run(15);
    chk("crono_ignored", {28'd0, mode_o}, 32'h1);
    sw = 4'b0010; run(12);
    chk("to_crono", {28'd0, mode_o}, 32'h2);
    chk("to_crono_conf", {31'd0, conflict_o}, 32'h0);
    sw = 4'b0000; run(12);
    sw = 4'b1100; run(12);
    chk("conf_mode", {28'd0, mode_o}, 32'h0);
    chk("conf_flag", {31'd0, conflict_o}, 32'h1);
    sw = 4'b0000; run(12);

    // randomized segments
    for (int s = 0; s < 30; s++) begin
      btn = 4'($urandom);
      sw  = 4'($urandom);
      run(int'($urandom_range(1, 25)));
    end
    btn = 4'b0000; sw = 4'b0000; run(20);

    // reset mid-operation
    sw = 4'b0001; btn = 4'b1000; run(40);
    chk("pre_rst_esc", {28'd0, mode_o}, 32'h1);
    #2 reset = 1'b0;
    raw_h[cyc] = 8'h00;
    #1;
    chk("rst_push", {28'd0, push_o}, 32'h0);
    chk("rst_mode", {28'd0, mode_o}, 32'h0);
    chk("rst_conf", {31'd0, conflict_o}, 32'h0);
    btn = 4'b0000;
    run(5);
    #1 reset = 1'b1;
    wait_mode(0, 20, lat);
    chk("rel_esc_lat", lat, 8);
    sw = 4'b0000; run(15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
